store_buffer_dmem: RTL and testbench

//  Data-side memory bridge downstream of the pipelined core's MEM stage.
//  - Core stores (d_w) retire in one cycle into a DEPTH-entry FIFO store buffer.
//  - The FIFO drains in order to the data RAM over a valid/ready write port.
//  - Core loads (d_r) are answered combinationally in the same cycle.
//  - Load data comes from the youngest matching buffered store (store-to-load forwarding), else from the RAM async read port.

---
 rtl/store_buffer_dmem_if.sv | 32 +++
 rtl/store_buffer_dmem.sv | 120 ++++++++++++
 tb/tb_store_buffer_dmem.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_dmem_if.sv
// Core-side and RAM-side signals of the data-memory store buffer bridge.
interface store_buffer_dmem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] ddata_w;
  logic              d_w;
  logic              d_r;
  logic [DATA_W-1:0] ddata_r;
  logic              sb_full;
  logic              sb_empty;
  logic              sb_ovf;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_wvalid;
  logic              ram_wready;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Driver side: core plus RAM model
  modport master (
    output daddr, ddata_w, d_w, d_r, ram_rdata, ram_wready,
    input  ddata_r, sb_full, sb_empty, sb_ovf, ram_raddr, ram_wvalid, ram_waddr, ram_wdata
  );

  // Bridge side
  modport slave (
    input  daddr, ddata_w, d_w, d_r, ram_rdata, ram_wready,
    output ddata_r, sb_full, sb_empty, sb_ovf, ram_raddr, ram_wvalid, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/store_buffer_dmem.sv
// Store buffer between the core MEM stage and the data RAM: single-cycle store
// retire into a FIFO, in-order drain over valid/ready, same-cycle loads with
// youngest-match store-to-load forwarding.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | buffer empty, no write presented to the RAM
// S_DRAIN | buffer non-empty, head entry presented for write
module store_buffer_dmem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  store_buffer_dmem_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic              enq;
  logic              deq;
  logic [PTR_W-1:0]  fwd_idx;

  // Full check uses the registered count: a slot freed this cycle is not reusable yet.
  assign enq = bus.d_w && (count_q != FULL_CNT);
  assign deq = (state_q == S_DRAIN) && bus.ram_wready;

  assign bus.sb_full    = (count_q == FULL_CNT);
  assign bus.sb_empty   = (count_q == '0);
  assign bus.sb_ovf     = ovf_q;
  assign bus.ram_raddr  = bus.daddr;
  assign bus.ram_wvalid = (state_q == S_DRAIN);
  assign bus.ram_waddr  = addr_q[rd_ptr_q];
  assign bus.ram_wdata  = data_q[rd_ptr_q];

  // State and storage registers; reset discards buffered stores without draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Drain FSM next state plus FIFO pointer/count/entry updates.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.d_w && (count_q == FULL_CNT));
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;

    unique case (state_q)
      S_IDLE:  if (enq) state_d = S_DRAIN;
      S_DRAIN: if (deq && (count_q == ONE_CNT) && !enq) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      addr_d[wr_ptr_q]  = {bus.daddr[ADDR_W-1:2], 2'b00};
      data_d[wr_ptr_q]  = bus.ddata_w;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (deq && !enq) count_d = count_q - 1'b1;
  end

  // Forwarding walks oldest to youngest so the youngest matching entry wins;
  // the head entry still in handshake is valid and therefore included.
  always_comb begin
    bus.ddata_r = bus.ram_rdata;
    fwd_idx     = rd_ptr_q;
    if (bus.d_r) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + PTR_W'(i);
        if (valid_q[fwd_idx] && (addr_q[fwd_idx][ADDR_W-1:2] == bus.daddr[ADDR_W-1:2]))
          bus.ddata_r = data_q[fwd_idx];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_dmem.sv
// Directed bench for store_buffer_dmem with hand-computed expectations.
module tb_store_buffer_dmem;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  store_buffer_dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_buffer_dmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core();
    bus.d_w     = 1'b0;
    bus.d_r     = 1'b0;
    bus.daddr   = '0;
    bus.ddata_w = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_core();
    bus.ram_rdata  = 32'hCAFE0000;
    bus.ram_wready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_full", 32'(bus.sb_full), 32'd0);
    chk("rst_wvalid", 32'(bus.ram_wvalid), 32'd0);
    chk("rst_ovf", 32'(bus.sb_ovf), 32'd0);
    chk("rst_waddr", bus.ram_waddr, 32'h0);
    chk("rst_wdata", bus.ram_wdata, 32'h0);
    step();
    reset = 1'b1;
    step();
    bus.d_r = 1'b1; bus.daddr = 32'h40;
    #1;
    chk("rst_load_ram", bus.ddata_r, 32'hCAFE0000);
    chk("rst_empty_after", 32'(bus.sb_empty), 32'd1);

    // Single store with an unaligned address, RAM always ready
    idle_core();
    bus.ram_wready = 1'b1;
    bus.d_w = 1'b1; bus.daddr = 32'h101; bus.ddata_w = 32'hDEADBEEF;
    step();
    idle_core();
    #1;
    chk("st1_wvalid", 32'(bus.ram_wvalid), 32'd1);
    chk("st1_waddr", bus.ram_waddr, 32'h100);
    chk("st1_wdata", bus.ram_wdata, 32'hDEADBEEF);
    chk("st1_empty_busy", 32'(bus.sb_empty), 32'd0);
    step();
    chk("st1_empty_done", 32'(bus.sb_empty), 32'd1);
    chk("st1_wvalid_done", 32'(bus.ram_wvalid), 32'd0);

    // Forwarding: youngest match wins, RAM stalled
    bus.ram_wready = 1'b0;
    bus.d_w = 1'b1; bus.daddr = 32'h10; bus.ddata_w = 32'h1;
    step();
    bus.ddata_w = 32'h2;
    step();
    idle_core();
    bus.d_r = 1'b1; bus.daddr = 32'h10;
    #1;
    chk("fwd_youngest", bus.ddata_r, 32'h2);
    bus.daddr = 32'h13;
    #1;
    chk("fwd_byte_ignored", bus.ddata_r, 32'h2);
    bus.daddr = 32'h14;
    #1;
    chk("fwd_miss", bus.ddata_r, 32'hCAFE0000);
    chk("fwd_head_addr", bus.ram_waddr, 32'h10);
    chk("fwd_head_data", bus.ram_wdata, 32'h1);
    // Load and store to the same word in one cycle: load sees the old state
    bus.d_w = 1'b1; bus.daddr = 32'h20; bus.ddata_w = 32'h7; bus.d_r = 1'b1;
    #1;
    chk("ld_st_same_cycle", bus.ddata_r, 32'hCAFE0000);
    step();
    bus.d_w = 1'b0;
    #1;
    chk("ld_next_cycle", bus.ddata_r, 32'h7);
    idle_core();
    bus.ram_wready = 1'b1;
    step();
    chk("drain_2nd_addr", bus.ram_waddr, 32'h10);
    chk("drain_2nd_data", bus.ram_wdata, 32'h2);
    step();
    chk("drain_3rd_addr", bus.ram_waddr, 32'h20);
    chk("drain_3rd_data", bus.ram_wdata, 32'h7);
    step();
    chk("drain_empty", 32'(bus.sb_empty), 32'd1);

    // Fill to DEPTH, then overflow
    bus.ram_wready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.d_w = 1'b1; bus.daddr = 32'h200 + 32'(4*i); bus.ddata_w = 32'h11 + 32'(i);
      step();
    end
    chk("fill_full", 32'(bus.sb_full), 32'd1);
    chk("fill_no_ovf", 32'(bus.sb_ovf), 32'd0);
    bus.daddr = 32'h210; bus.ddata_w = 32'h99;
    step();
    bus.d_w = 1'b0; bus.d_r = 1'b1;
    #1;
    chk("ovf_set", 32'(bus.sb_ovf), 32'd1);
    chk("ovf_still_full", 32'(bus.sb_full), 32'd1);
    chk("ovf_dropped_not_fwd", bus.ddata_r, 32'hCAFE0000);
    idle_core();
    bus.ram_wready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("order_addr", bus.ram_waddr, 32'h200 + 32'(4*i));
      chk("order_data", bus.ram_wdata, 32'h11 + 32'(i));
      step();
    end
    chk("order_empty", 32'(bus.sb_empty), 32'd1);
    chk("ovf_sticky", 32'(bus.sb_ovf), 32'd1);

    // Reset, then full buffer with store and RAM ready in the same cycle
    reset = 1'b0;
    #1;
    chk("rst2_ovf_clear", 32'(bus.sb_ovf), 32'd0);
    step();
    reset = 1'b1;
    bus.ram_wready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.d_w = 1'b1; bus.daddr = 32'h300 + 32'(4*i); bus.ddata_w = 32'h30 + 32'(i);
      step();
    end
    chk("fill2_full", 32'(bus.sb_full), 32'd1);
    bus.daddr = 32'h3F0; bus.ddata_w = 32'hBAD;
    bus.ram_wready = 1'b1;
    step();
    idle_core();
    bus.ram_wready = 1'b0;
    #1;
    chk("fd_ovf", 32'(bus.sb_ovf), 32'd1);
    chk("fd_not_full", 32'(bus.sb_full), 32'd0);
    chk("fd_head_addr", bus.ram_waddr, 32'h304);
    bus.d_r = 1'b1; bus.daddr = 32'h3F0;
    #1;
    chk("fd_dropped_not_fwd", bus.ddata_r, 32'hCAFE0000);
    bus.d_r = 1'b0;

    // Stall: head must hold for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wvalid", 32'(bus.ram_wvalid), 32'd1);
      chk("stall_addr", bus.ram_waddr, 32'h304);
      chk("stall_data", bus.ram_wdata, 32'h31);
    end
    // Reset mid-stall abandons the write immediately
    reset = 1'b0;
    #1;
    chk("rst_stall_wvalid", 32'(bus.ram_wvalid), 32'd0);
    chk("rst_stall_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_stall_full", 32'(bus.sb_full), 32'd0);
    step();
    reset = 1'b1;
    bus.d_r = 1'b1; bus.daddr = 32'h304;
    #1;
    chk("rst_stall_no_fwd", bus.ddata_r, 32'hCAFE0000);
    idle_core();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
